// File: rtl/ay_3_8910_capcom.sv
// AY-3-8910 PSG core as used on the Capcom 1942 sound board: tone, noise, envelope and mixer.
// Define AY_REG_DUMP_EN to compile the data-port write trace; dump_regs=1 then enables it.
module ay_3_8910_capcom #(
  parameter int dump_regs = 0,
  parameter int id        = 0,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       adr,
  input  logic       wr_n,
  input  logic       cs_n,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [7:0]       regs_r [16];
  logic [3:0]       addr_r;
  logic             wr_s, data_wr_s, env_restart_s;
  logic [DIV_W-1:0] div_r;
  logic             tick_s, tone_clk_s, noise_clk_s, env_clk_s;
  logic [2:0]       tone_pre_r;
  logic [3:0]       noise_pre_r, env_pre_r;
  logic [4:0]       noise_cnt_r, np_lim_s;
  logic [16:0]      lfsr_r;
  logic [15:0]      env_cnt_r, ep_s, ep_lim_s;
  logic [3:0]       env_step_r, env_level_s;
  logic             env_hold_r, env_inv_r;
  logic             unused_regs_s;

  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  assign wr_s          = ~cs_n & ~wr_n;
  assign data_wr_s     = wr_s & adr;
  assign env_restart_s = data_wr_s & (addr_r == 4'd13);

  // Address latch and register file; address bytes with a nonzero high nibble are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= 4'd0;
      regs_r <= '{default: 8'd0};
    end else if (wr_s) begin
      if (!adr) begin
        if (din[7:4] == 4'd0) addr_r <= din[3:0];
      end else begin
        regs_r[addr_r] <= din & reg_mask(addr_r);
      end
    end
  end

  assign tick_s      = (div_r == DIV_MAX);
  assign tone_clk_s  = tick_s & (tone_pre_r == 3'd7);
  assign noise_clk_s = tick_s & (noise_pre_r == 4'd15);
  assign env_clk_s   = tick_s & (env_pre_r == 4'd15);

  // Master tick divider plus tone and noise prescalers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r       <= {DIV_W{1'b0}};
      tone_pre_r  <= 3'd0;
      noise_pre_r <= 4'd0;
    end else begin
      div_r <= tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
      if (tick_s) begin
        tone_pre_r  <= tone_pre_r + 3'd1;
        noise_pre_r <= noise_pre_r + 4'd1;
      end
    end
  end

  assign np_lim_s = (regs_r[6][4:0] == 5'd0) ? 5'd0 : regs_r[6][4:0] - 5'd1;

  // Noise period counter and 17-bit LFSR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      noise_cnt_r <= 5'd0;
      lfsr_r      <= 17'h1;
    end else if (noise_clk_s) begin
      if (noise_cnt_r >= np_lim_s) begin
        noise_cnt_r <= 5'd0;
        lfsr_r      <= {lfsr_r[0] ^ lfsr_r[3], lfsr_r[16:1]};
      end else begin
        noise_cnt_r <= noise_cnt_r + 5'd1;
      end
    end
  end

  assign ep_s     = {regs_r[12], regs_r[11]};
  assign ep_lim_s = (ep_s == 16'd0) ? 16'd0 : ep_s - 16'd1;

  // Envelope sequencer; a write to R13 restarts it, including its prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      env_pre_r  <= 4'd0;
      env_cnt_r  <= 16'd0;
      env_step_r <= 4'd0;
      env_hold_r <= 1'b0;
      env_inv_r  <= 1'b0;
    end else if (env_restart_s) begin
      env_pre_r  <= 4'd0;
      env_cnt_r  <= 16'd0;
      env_step_r <= 4'd0;
      env_hold_r <= 1'b0;
      env_inv_r  <= 1'b0;
    end else begin
      if (tick_s) env_pre_r <= env_pre_r + 4'd1;
      if (env_clk_s) begin
        if (env_cnt_r >= ep_lim_s) begin
          env_cnt_r <= 16'd0;
          if (!env_hold_r) begin
            if (env_step_r == 4'd15) begin
              if (!regs_r[13][3] || regs_r[13][0]) begin
                env_hold_r <= 1'b1;
              end else begin
                env_step_r <= 4'd0;
                env_inv_r  <= env_inv_r ^ regs_r[13][1];
              end
            end else begin
              env_step_r <= env_step_r + 4'd1;
            end
          end
        end else begin
          env_cnt_r <= env_cnt_r + 16'd1;
        end
      end
    end
  end

  // Held level: 0 without CONT, else the final attack level flipped by ALT
  always_comb begin
    env_level_s = 4'd0;
    if (env_hold_r) begin
      if (regs_r[13][3] && (regs_r[13][2] ^ regs_r[13][1])) env_level_s = 4'hF;
      else env_level_s = 4'h0;
    end else begin
      env_level_s = (regs_r[13][2] ? env_step_r : ~env_step_r) ^ {4{env_inv_r}};
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    logic [11:0] tp_s, tp_lim_s, tone_cnt_r;
    logic        tone_ff_r, gate_s;
    logic [3:0]  level_s, out_r;

    assign tp_s     = {regs_r[2*g+1][3:0], regs_r[2*g]};
    assign tp_lim_s = (tp_s == 12'd0) ? 12'd0 : tp_s - 12'd1;
    assign level_s  = regs_r[8+g][4] ? env_level_s : regs_r[8+g][3:0];
    assign gate_s   = (tone_ff_r | regs_r[7][g]) & (lfsr_r[0] | regs_r[7][3+g]);

    // Tone counter: >= compare so a lowered period toggles on the next tone clock
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        tone_cnt_r <= 12'd0;
        tone_ff_r  <= 1'b0;
      end else if (tone_clk_s) begin
        if (tone_cnt_r >= tp_lim_s) begin
          tone_cnt_r <= 12'd0;
          tone_ff_r  <= ~tone_ff_r;
        end else begin
          tone_cnt_r <= tone_cnt_r + 12'd1;
        end
      end
    end

    // Registered channel amplitude
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_r <= 4'd0;
      else out_r <= gate_s ? level_s : 4'd0;
    end
  end

  assign A = g_chan[0].out_r;
  assign B = g_chan[1].out_r;
  assign C = g_chan[2].out_r;

  assign unused_regs_s = ^{regs_r[7][7:6], regs_r[14], regs_r[15], regs_r[1][7:4],
                           regs_r[3][7:4], regs_r[5][7:4], regs_r[6][7:5], regs_r[8][7:5],
                           regs_r[9][7:5], regs_r[10][7:5], regs_r[13][7:4]};

`ifdef AY_REG_DUMP_EN
  // Data-port write trace
  always @(posedge clk) begin
    if (dump_regs != 0 && reset_n && data_wr_s)
      $display("%0t: ay%0d r%0d = %0d", $time, id, addr_r, din);
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (dump_regs != 0) ^ (id != 0);
`endif

endmodule

// File: tb/tb_ay_3_8910_capcom.sv
// Directed, table-driven bench for ay_3_8910_capcom (CLK_DIV=2).
module tb_ay_3_8910_capcom;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       adr = 1'b0;
  logic       wr_n = 1'b1;
  logic       cs_n = 1'b1;
  logic [3:0] A, B, C;

  ay_3_8910_capcom #(.dump_regs(0), .id(0), .CLK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .adr(adr), .wr_n(wr_n), .cs_n(cs_n),
    .A(A), .B(B), .C(C)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bc_bad = 0;
  int cap_val [64];
  int cap_t   [64];
  int cap_n = 0;
  logic [7:0] shadow [16];

  typedef struct packed {
    logic [3:0] r;
    logic [7:0] v;
    logic [7:0] e;
  } vec_t;
  vec_t vecs [12];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; adr = a; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wr_reg(input logic [3:0] r, input logic [7:0] v);
    bus_wr(1'b0, {4'd0, r});
    bus_wr(1'b1, v);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Records up to n changes of A (value and cycle), giving up after budget cycles.
  task automatic capture(input int n, input int budget);
    int last;
    last = int'(A);
    cap_n = 0;
    for (int c = 0; c < budget && cap_n < n; c++) begin
      @(negedge clk);
      if (B != 4'd0 || C != 4'd0) bc_bad++;
      if (int'(A) != last) begin
        cap_val[cap_n] = int'(A);
        cap_t[cap_n]   = cyc;
        cap_n++;
        last = int'(A);
      end
    end
  endtask

  function automatic int regs_nonzero();
    int nz = 0;
    for (int i = 0; i < 16; i++) if (dut.regs_r[i] != 8'd0) nz++;
    return nz;
  endfunction

  initial begin
    int found;
    int prev;
    int nz;
    logic [16:0] s;

    vecs[0]  = '{4'd0,  8'hFF, 8'hFF};
    vecs[1]  = '{4'd1,  8'hFF, 8'h0F};
    vecs[2]  = '{4'd3,  8'h12, 8'h02};
    vecs[3]  = '{4'd6,  8'hFF, 8'h1F};
    vecs[4]  = '{4'd7,  8'hFF, 8'hFF};
    vecs[5]  = '{4'd8,  8'h0A, 8'h0A};
    vecs[6]  = '{4'd11, 8'hA5, 8'hA5};
    vecs[7]  = '{4'd12, 8'h3C, 8'h3C};
    vecs[8]  = '{4'd13, 8'hFF, 8'h0F};
    vecs[9]  = '{4'd10, 8'hE7, 8'h07};
    vecs[10] = '{4'd15, 8'hC3, 8'hC3};
    vecs[11] = '{4'd14, 8'h55, 8'h55};
    for (int i = 0; i < 16; i++) shadow[i] = 8'd0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_A", A, 0); check("rst_B", B, 0); check("rst_C", C, 0);
    check("rst_regs_nonzero", regs_nonzero(), 0);
    check("rst_addr", dut.addr_r, 0);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_A", A, 0); check("idle_B", B, 0); check("idle_C", C, 0);

    // register writes with masking
    for (int i = 0; i < 12; i++) begin
      wr_reg(vecs[i].r, vecs[i].v);
      shadow[vecs[i].r] = vecs[i].e;
      check($sformatf("reg_r%0d", vecs[i].r), dut.regs_r[vecs[i].r], vecs[i].e);
    end
    bus_wr(1'b0, 8'h18);
    bus_wr(1'b1, 8'h55);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.regs_r[i] != shadow[i]) nz++;
    check("addr_filter_changes", nz, 0);
    wr_reg(4'd8, 8'hFF);
    check("r8_masked", dut.regs_r[8], 8'h1F);

    // tone on A, period TP=1
    pulse_reset();
    wr_reg(4'd0, 8'h01); wr_reg(4'd1, 8'h00); wr_reg(4'd7, 8'h3E); wr_reg(4'd8, 8'h0F);
    bc_bad = 0;
    capture(8, 300);
    check("tone_changes", cap_n, 8);
    check("tone_first_valid", int'(cap_val[0] == 0 || cap_val[0] == 15), 1);
    for (int k = 1; k < cap_n; k++) begin
      check($sformatf("tone_val%0d", k), cap_val[k], 15 - cap_val[k-1]);
      check($sformatf("tone_gap%0d", k), cap_t[k] - cap_t[k-1], 16);
    end
    check("tone_bc_quiet", bc_bad, 0);

    // asynchronous reset in the middle of a tone high phase
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (A == 4'd15) found = 1;
    end
    check("tone_high_seen", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_A", A, 0); check("async_rst_B", B, 0); check("async_rst_C", C, 0);
    check("async_rst_regs", regs_nonzero(), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // envelope attack + hold
    wr_reg(4'd7, 8'h3F); wr_reg(4'd8, 8'h10); wr_reg(4'd11, 8'h01);
    wr_reg(4'd12, 8'h00); wr_reg(4'd13, 8'h0D);
    @(negedge clk);
    check("env_start", A, 0);
    bc_bad = 0;
    capture(15, 700);
    check("env_ramp_changes", cap_n, 15);
    for (int k = 0; k < cap_n; k++) begin
      check($sformatf("env_ramp%0d", k), cap_val[k], k + 1);
      if (k > 0) check($sformatf("env_gap%0d", k), cap_t[k] - cap_t[k-1], 32);
    end
    capture(1, 600);
    check("env_hold_changes", cap_n, 0);
    check("env_hold_level", A, 15);
    wr_reg(4'd13, 8'h0D);
    @(negedge clk);
    check("env_restart", A, 0);
    capture(1, 60);
    check("env_restart_step", cap_n, 1);
    check("env_restart_val", cap_val[0], 1);

    // sawtooth down, repeating
    wr_reg(4'd13, 8'h08);
    @(negedge clk);
    check("saw_start", A, 15);
    capture(32, 1100);
    check("saw_changes", cap_n, 32);
    for (int k = 0; k < cap_n; k++) begin
      prev = (k == 0) ? 15 : cap_val[k-1];
      check($sformatf("saw_val%0d", k), cap_val[k], (prev == 0) ? 15 : prev - 1);
      if (k > 0) check($sformatf("saw_gap%0d", k), cap_t[k] - cap_t[k-1], 32);
    end
    check("saw_period", cap_t[31] - cap_t[15], 512);
    wr_reg(4'd11, 8'h00);
    capture(4, 200);
    check("ep0_changes", cap_n, 4);
    for (int k = 1; k < cap_n; k++)
      check($sformatf("ep0_gap%0d", k), cap_t[k] - cap_t[k-1], 32);
    check("env_bc_quiet", bc_bad, 0);

    // noise on A, NP=0 acts as 1
    pulse_reset();
    wr_reg(4'd7, 8'h37); wr_reg(4'd6, 8'h00); wr_reg(4'd8, 8'h0F);
    @(negedge clk);
    check("noise_seed", A, 15);
    capture(1, 100);
    check("noise_first_shift", cap_n, 1);
    s = 17'h1;
    s = {s[0] ^ s[3], s[16:1]};
    repeat (16) @(negedge clk);
    for (int k = 1; k <= 30; k++) begin
      check($sformatf("noise%0d", k), A, s[0] ? 15 : 0);
      s = {s[0] ^ s[3], s[16:1]};
      repeat (32) @(negedge clk);
    end
    check("noise_B", B, 0); check("noise_C", C, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ay_3_8910_capcom.md
Name: ay_3_8910_capcom

Overview:
- Single-clock RTL model of the AY-3-8910 programmable sound generator, as wired on the Capcom 1942 sound board (two instances at 0x8000/0x8001 and 0xC000/0xC001).
- Z80 writes go through an address/data port pair.
- The block produces three 4-bit channel amplitudes (A, B, C) that feed downstream PWM DACs.

Parameters:
- dump_regs, 0: 1 enables the register-write trace (see Optional Feature).
- id, 0: instance number printed in the trace.
- CLK_DIV, 2: clk cycles per PSG master tick. Default 2 gives 1.5 MHz from a 3 MHz clk.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- din  in  8  CPU write data.
- adr  in  1  0 = address latch, 1 = data register.
- wr_n  in  1  active-low write strobe.
- cs_n  in  1  active-low chip select.
- A  out  4  channel A amplitude.
- B  out  4  channel B amplitude.
- C  out  4  channel C amplitude.

Behaviour:
- Reset (async):
  - All 16 registers and the address latch = 0.
  - All counters = 0; tone flip-flops = 0; noise LFSR = 17'h1; envelope step = 0.
  - A/B/C = 0.
- Write:
  - A write occurs on every rising clk edge with cs_n=0 and wr_n=0.
  - Repeated writes during one long strobe are idempotent, except that rewriting R13 keeps restarting the envelope.
  - adr=0: if din[7:4]==0, latch din[3:0] as the register address; otherwise ignore.
  - adr=1: write din to the selected register, masked to its width.
  - The effect is visible on the next clk.
- Register map (unused bits read 0 internally):
  - R0/R2/R4: tone period fine (8 bits) for A/B/C.
  - R1/R3/R5: tone period coarse (4 bits), giving 12-bit TP.
  - R6: noise period NP (5 bits).
  - R7 mixer: bits2:0 tone disable C,B,A (bit0 = A); bits5:3 noise disable (bit3 = A); bits7:6 stored, no effect.
  - R8–R10: bit4 = envelope mode, bits3:0 = fixed level.
  - R11/R12: envelope period EP, 16 bits (R11 low).
  - R13: shape, 4 bits = CONT, ATT, ALT, HOLD (bits 3..0). Writing R13 restarts the envelope at step 0.
  - R14/R15: stored only.
- Tick: an internal divider asserts a one-clk tick every CLK_DIV clks. All PSG counters advance only on tick.
- Tone:
  - A /8 prescaler on tick produces one tone clock per 8 ticks.
  - Per channel, a 12-bit counter increments on each tone clock. When counter ≥ max(TP,1)−1, the counter clears and the tone flip-flop toggles.
  - Full period = 16·max(TP,1) ticks.
  - Lowering TP below the current count causes a toggle on the next tone clock (no wrap-around).
- Noise:
  - A /16 prescaler on tick drives a 5-bit counter with period max(NP,1).
  - At each period the LFSR shifts right, with new bit16 = bit0 XOR bit3. Noise bit = LFSR bit0.
- Envelope:
  - A /16 prescaler on tick drives a 16-bit counter with period max(EP,1).
  - At each period, step advances 0→15. One cycle = 256·max(EP,1) ticks.
  - Level within a cycle = step if ATT=1, else 15−step.
  - After the first cycle:
    - CONT=0: hold 0.
    - HOLD=1: hold the final level, inverted if ALT=1.
    - ALT=1: invert the direction each cycle.
    - Otherwise: repeat.
  - Shapes 0–3 ≡ 9; shapes 4–7 ≡ 15.
- Output:
  - gate = (tone | toneDis) & (noise | noiseDis).
  - level = envelope mode ? env level : fixed level.
  - X = gate ? level : 0, registered (one clk latency). Both disables set → constant level.

Optional Feature:
- Macro AY_REG_DUMP_EN.
- Defined and dump_regs=1: every data-port write executes $display of the simulation time, id, register number and value (decimal). Synthesis ignores it.
- Undefined: no trace code is compiled, regardless of dump_regs.

Test Plan:
- Reset: assert reset_n=0 mid-tone → A=B=C=0 immediately; registers read back 0 (via hierarchy); after release, outputs stay 0 until a write.
- Tone: CLK_DIV=2; R0=1, R1=0, R7=0x3E, R8=0x0F → A toggles 0↔15 every 16 clk (period 32 clk); B=C=0.
- Address filtering: address write 0x18, then data 0x55 → no register changes. Address write 0x08, data 0xFF → R8=0x1F, masked.
- Envelope: R7=0x3F, R8=0x10, R11=1, R12=0, R13=0x0D (attack, hold) → A ramps 0,1,…,15, one step per 32 clk, then holds 15. Rewrite R13 → restarts at 0.
- Sawtooth: R13=0x08 → 15→0 repeating, period 512 clk with EP=1. Envelope period 0 behaves as 1.
- Noise: R7=0x37, R6=0, R8=0x0F → A follows LFSR bit0: first outputs taken from seed 1 sequence (15, 0, …), one update every 32 clk; noise period 0 behaves as 1.
